alu_writeback: RTL and testbench

Result/flag retirement stage directly downstream of the ALU. Accepts one ALU result per handshake and decides from `op`/`exop` whether it writes the register file, updates the processor status register (PSR), or both. It buffers up to two pending register writes and drains them in order through a register-file write port that may stall. It feeds the PSR carry back to the ALU `Cin` and publishes a pending-destination mask for upstream hazard checks.

---
 rtl/alu_writeback.sv | 155 +++++++++++++++
 tb/tb_alu_writeback.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - ALU result/flag retirement stage with a 2-entry register-write buffer
//
// Purpose: retires one ALU result per handshake. The opcode/extended opcode decide
// whether the result is queued for a register-file write, whether the flags load the
// PSR, or both. Up to two register writes are buffered and drained in order.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   in_valid/in_ready            ALU result handshake (in_ready depends only on fill level)
//   in_op, in_exop               opcode / extended opcode of the retiring instruction
//   in_dest, in_result, in_flags destination, ALU result, ALU flags {slt,eq,ovf,ult,carry}
//   rf_we/rf_waddr/rf_wdata      head-of-buffer write request to the register file
//   rf_ready                     register file accepts the write on this edge
//   psr, cin_out                 processor status register and its carry bit for ALU Cin
//   busy_mask                    one bit per register with a pending buffered write
//   retired_count                wrapping count of accepted instructions
module alu_writeback #(
  parameter int DATA_W = 16,
  parameter int AREG_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [3:0]        in_exop,
  input  logic [AREG_W-1:0] in_dest,
  input  logic [DATA_W-1:0] in_result,
  input  logic [4:0]        in_flags,
  output logic              rf_we,
  output logic [AREG_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic              rf_ready,
  output logic [4:0]        psr,
  output logic              cin_out,
  output logic [15:0]       busy_mask,
  output logic [15:0]       retired_count
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t              state, state_next;
  logic [AREG_W-1:0]   tail_addr;
  logic [DATA_W-1:0]   tail_data;
  logic                is_write, is_psr;
  logic                accept, write_accept, drain;
  logic                load_head, load_tail, shift_tail;

  // Instruction class decode.
  always_comb begin
    is_write = 1'b0;
    is_psr   = 1'b0;
    case (in_op)
      4'b0000: begin
        case (in_exop)
          4'b0001, 4'b0010, 4'b0011, 4'b0100: is_write = 1'b1;
          4'b0101, 4'b0110, 4'b0111, 4'b1001, 4'b1010: begin
            is_write = 1'b1;
            is_psr   = 1'b1;
          end
          4'b1011, 4'b1000: is_psr = 1'b1;
          default: ;
        endcase
      end
      4'b1000: begin
        case (in_exop)
          4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000: is_write = 1'b1;
          default: ;
        endcase
      end
      4'b0101, 4'b0110, 4'b0111, 4'b1101, 4'b1001: begin
        is_write = 1'b1;
        is_psr   = 1'b1;
      end
      4'b0001, 4'b0011: is_write = 1'b1;
      4'b1011:          is_psr   = 1'b1;
      default: ;
    endcase
  end

  assign in_ready     = (state != FULL);
  assign rf_we        = (state != EMPTY);
  assign accept       = in_valid & in_ready;
  assign write_accept = accept & is_write;
  assign drain        = rf_we & rf_ready;
  assign cin_out      = psr[0];

  always_comb begin
    state_next = state;
    load_head  = 1'b0;
    load_tail  = 1'b0;
    shift_tail = 1'b0;
    case (state)
      EMPTY: begin
        if (write_accept) begin
          load_head  = 1'b1;
          state_next = ONE;
        end
      end
      ONE: begin
        // Simultaneous drain and write: the incoming entry replaces the head.
        if (drain && write_accept) begin
          load_head = 1'b1;
        end else if (drain) begin
          state_next = EMPTY;
        end else if (write_accept) begin
          load_tail  = 1'b1;
          state_next = FULL;
        end
      end
      FULL: begin
        // No accept is possible here; a drain promotes the tail.
        if (drain) begin
          shift_tail = 1'b1;
          state_next = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= EMPTY;
      rf_waddr      <= '0;
      rf_wdata      <= '0;
      tail_addr     <= '0;
      tail_data     <= '0;
      psr           <= '0;
      retired_count <= '0;
    end else begin
      state <= state_next;
      if (load_head) begin
        rf_waddr <= in_dest;
        rf_wdata <= in_result;
      end else if (shift_tail) begin
        rf_waddr <= tail_addr;
        rf_wdata <= tail_data;
      end
      if (load_tail) begin
        tail_addr <= in_dest;
        tail_data <= in_result;
      end
      if (accept && is_psr) psr <= in_flags;
      if (accept) retired_count <= retired_count + 16'd1;
    end
  end

  always_comb begin
    busy_mask = '0;
    if (state != EMPTY) busy_mask = busy_mask | (16'b1 << rf_waddr);
    if (state == FULL)  busy_mask = busy_mask | (16'b1 << tail_addr);
  end

endmodule

// File: tb/tb_alu_writeback.sv
// tb/tb_alu_writeback.sv - self-checking testbench for alu_writeback
module tb_alu_writeback;

  typedef struct packed {
    logic [3:0]  a;
    logic [15:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op, in_exop, in_dest;
  logic [15:0] in_result;
  logic [4:0]  in_flags;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        rf_ready;
  logic [4:0]  psr;
  logic        cin_out;
  logic [15:0] busy_mask;
  logic [15:0] retired_count;

  int checks = 0;
  int failures = 0;

  ent_t        mq[$];
  ent_t        m_last;
  logic [4:0]  m_psr;
  logic [15:0] m_ret;

  always #5 clk = ~clk;

  alu_writeback #(.DATA_W(16), .AREG_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_exop(in_exop), .in_dest(in_dest), .in_result(in_result),
    .in_flags(in_flags), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_ready(rf_ready), .psr(psr), .cin_out(cin_out), .busy_mask(busy_mask),
    .retired_count(retired_count)
  );

  function automatic bit writes_rf(input logic [3:0] op, input logic [3:0] ex);
    if (op == 4'h0) return ex inside {4'h5, 4'h6, 4'h7, 4'hA, 4'h9, 4'h1, 4'h2, 4'h3, 4'h4};
    if (op == 4'h8) return ex inside {4'h4, 4'h8, 4'h5, 4'h7, 4'h6, 4'h3};
    return op inside {4'h5, 4'h6, 4'h7, 4'hD, 4'h9, 4'h3, 4'h1};
  endfunction

  function automatic bit writes_psr(input logic [3:0] op, input logic [3:0] ex);
    if (op == 4'h0) return ex inside {4'h5, 4'h6, 4'h7, 4'hA, 4'h9, 4'hB, 4'h8};
    return op inside {4'h5, 4'h6, 4'h7, 4'hD, 4'h9, 4'hB};
  endfunction

  function automatic logic [15:0] model_mask();
    logic [15:0] m = '0;
    foreach (mq[i]) m[mq[i].a] = 1'b1;
    return m;
  endfunction

  task automatic model_clear();
    mq.delete();
    m_last = '0;
    m_psr  = '0;
    m_ret  = '0;
  endtask

  // Advance one clock, updating the reference model from the inputs seen at the edge.
  task automatic tick();
    bit acc, drn;
    acc = in_valid && (mq.size() != 2);
    drn = (mq.size() != 0) && rf_ready;
    @(posedge clk);
    if (reset_n) begin
      if (drn) void'(mq.pop_front());
      if (acc && writes_rf(in_op, in_exop)) mq.push_back({in_dest, in_result});
      if (acc && writes_psr(in_op, in_exop)) m_psr = in_flags;
      if (acc) m_ret = m_ret + 16'd1;
      if (mq.size() != 0) m_last = mq[0];
    end
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [3:0] ex, input logic [3:0] dst,
                       input logic [15:0] res, input logic [4:0] fl);
    in_valid = 1'b1; in_op = op; in_exop = ex; in_dest = dst; in_result = res; in_flags = fl;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; rf_ready = 1'b0;
    in_op = '0; in_exop = '0; in_dest = '0; in_result = '0; in_flags = '0;
    model_clear();
    repeat (2) tick();
    reset_n = 1'b1;
    drive(4'h0, 4'h5, 4'd4, 16'h1234, 5'b11111); tick();
    drive(4'h0, 4'h5, 4'd6, 16'h5678, 5'b11111); tick();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || psr !== 5'b11111) begin
      failures++; $display("FAIL reset_setup: in_ready=%b psr=%b required 0/11111", in_ready, psr);
    end
    // Asynchronous assertion mid-cycle, no clock edge in between.
    reset_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, psr, cin_out, busy_mask, retired_count, in_ready} !== {59'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset_async: we=%b a=%h d=%h psr=%b cin=%b busy=%h ret=%h rdy=%b required zeros, rdy=1",
               rf_we, rf_waddr, rf_wdata, psr, cin_out, busy_mask, retired_count, in_ready);
    end
    drive(4'h0, 4'h5, 4'd2, 16'hBEEF, 5'b10101);
    tick(); tick();
    checks++;
    if (retired_count !== 16'd0 || rf_we !== 1'b0 || psr !== 5'd0) begin
      failures++; $display("FAIL reset_hold: ret=%h we=%b psr=%b required 0/0/0", retired_count, rf_we, psr);
    end
    in_valid = 1'b0;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_add();
    rf_ready = 1'b1;
    drive(4'h0, 4'h5, 4'd3, 16'h0007, 5'b00100); tick();
    in_valid = 1'b0;
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, psr, busy_mask} !== {1'b1, 4'd3, 16'h0007, 5'b00100, 16'h0008}) begin
      failures++;
      $display("FAIL add_result: we=%b a=%h d=%h psr=%b busy=%h required 1/3/0007/00100/0008",
               rf_we, rf_waddr, rf_wdata, psr, busy_mask);
    end
    tick();
    checks++;
    if (busy_mask !== 16'h0000 || rf_we !== 1'b0 || rf_waddr !== 4'd3) begin
      failures++; $display("FAIL add_drain: busy=%h we=%b a=%h required 0000/0/3", busy_mask, rf_we, rf_waddr);
    end
  endtask

  task automatic test_cmp();
    logic [15:0] r0;
    r0 = retired_count;
    drive(4'h0, 4'hB, 4'd9, 16'hFFFF, 5'b10000); tick();
    in_valid = 1'b0;
    checks++;
    if (rf_we !== 1'b0 || psr !== 5'b10000 || busy_mask !== 16'h0 || retired_count !== r0 + 16'd1) begin
      failures++;
      $display("FAIL cmp: we=%b psr=%b busy=%h ret=%h required 0/10000/0000/%h",
               rf_we, psr, busy_mask, retired_count, r0 + 16'd1);
    end
  endtask

  task automatic test_back_to_back();
    rf_ready = 1'b0;
    drive(4'h1, 4'h0, 4'd1, 16'h0011, 5'd0); tick();
    drive(4'h1, 4'h0, 4'd2, 16'h0022, 5'd0); tick();
    drive(4'h1, 4'h0, 4'd5, 16'h0055, 5'd0); tick();
    checks++;
    if (in_ready !== 1'b0 || busy_mask !== 16'h0006 || rf_waddr !== 4'd1) begin
      failures++; $display("FAIL bp_full: rdy=%b busy=%h a=%h required 0/0006/1", in_ready, busy_mask, rf_waddr);
    end
    rf_ready = 1'b1;
    tick();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 4'd2 || rf_wdata !== 16'h0022 || busy_mask !== 16'h0004) begin
      failures++;
      $display("FAIL bp_drain1: we=%b a=%h d=%h busy=%h required 1/2/0022/0004", rf_we, rf_waddr, rf_wdata, busy_mask);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 4'd5 || rf_wdata !== 16'h0055 || busy_mask !== 16'h0020) begin
      failures++;
      $display("FAIL bp_drain2: we=%b a=%h d=%h busy=%h required 1/5/0055/0020", rf_we, rf_waddr, rf_wdata, busy_mask);
    end
    tick();
    checks++;
    if (rf_we !== 1'b0 || busy_mask !== 16'h0) begin
      failures++; $display("FAIL bp_empty: we=%b busy=%h required 0/0000", rf_we, busy_mask);
    end
  endtask

  task automatic test_carry();
    drive(4'h0, 4'hA, 4'd7, 16'h8000, 5'b00001); tick();
    checks++;
    if (cin_out !== 1'b1 || psr !== 5'b00001) begin
      failures++; $display("FAIL addcu_cin: cin=%b psr=%b required 1/00001", cin_out, psr);
    end
    drive(4'h1, 4'h0, 4'd8, 16'h00F0, 5'b01000); tick();
    in_valid = 1'b0;
    checks++;
    if (psr !== 5'b00001 || rf_we !== 1'b1 || rf_waddr !== 4'd8 || rf_wdata !== 16'h00F0) begin
      failures++;
      $display("FAIL andi: psr=%b we=%b a=%h d=%h required 00001/1/8/00F0", psr, rf_we, rf_waddr, rf_wdata);
    end
    tick();
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = 4'($urandom);
      in_exop   = 4'($urandom);
      in_dest   = 4'($urandom);
      in_result = 16'($urandom);
      in_flags  = 5'($urandom);
      rf_ready  = ($urandom_range(0, 1) == 1);
      tick();
      checks++;
      if (rf_we !== (mq.size() != 0) || rf_waddr !== m_last.a || rf_wdata !== m_last.d ||
          in_ready !== (mq.size() != 2) || psr !== m_psr || cin_out !== m_psr[0] ||
          busy_mask !== model_mask() || retired_count !== m_ret) begin
        failures++;
        if (bad < 5)
          $display("FAIL random[%0d]: we=%b a=%h d=%h rdy=%b psr=%b cin=%b busy=%h ret=%h required %b/%h/%h/%b/%b/%b/%h/%h",
                   i, rf_we, rf_waddr, rf_wdata, in_ready, psr, cin_out, busy_mask, retired_count,
                   mq.size() != 0, m_last.a, m_last.d, mq.size() != 2, m_psr, m_psr[0], model_mask(), m_ret);
        bad++;
      end
    end
    in_valid = 1'b0;
    rf_ready = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_wrap();
    reset_n = 1'b0;
    model_clear();
    in_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    drive(4'h2, 4'h0, 4'd0, 16'h0, 5'b11111);
    repeat (65535) tick();
    checks++;
    if (retired_count !== 16'hFFFF || rf_we !== 1'b0 || psr !== 5'd0) begin
      failures++; $display("FAIL wrap_pre: ret=%h we=%b psr=%b required FFFF/0/00000", retired_count, rf_we, psr);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (retired_count !== 16'h0000) begin
      failures++; $display("FAIL wrap: ret=%h required 0000", retired_count);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_cmp();
    test_back_to_back();
    test_carry();
    test_random();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
